scan_display_ctrl: RTL and testbench
====================================

// Module: scan_display_ctrl
// PURPOSE
//  Parametrised multiplexed 7-segment scanner, successor to the fixed 4-digit score display.
//  Time-multiplexes N_DIGITS hex nibbles onto one shared segment bus with one-hot anode select.
//  Adds an internal scan divider, tear-free frame-synchronous value update and an anti-ghost guard.
//  Also adds leading-zero blanking, per-digit decimal point and per-digit blink.
//  Sits between game/score logic and the board 7-seg pins.
// PARAMETERS
//  N_DIGITS     4       digits driven, 1..8
//  SCAN_DIV     50000   clk cycles per digit slot, >= 2
//  GUARD        16      cycles at start of each slot with all anodes off, 0..SCAN_DIV-1
//  BLINK_FRAMES 64      full scan frames per blink half-period, >= 1
// PORTS
//  clk        in   1           system clock, all logic on rising edge
//  rst        in   1           asynchronous, active-high reset
//  value      in   4*N_DIGITS  hex nibbles; nibble i = value[4i+3:4i]; digit 0 is rightmost
//  load       in   1           1-cycle strobe: capture value into shadow register
//  dp         in   N_DIGITS    decimal point on per digit (sampled live)
//  blink_en   in   N_DIGITS    digit blanks during blink-off phase (sampled live)
//  blank_lz   in   1           1 = suppress leading zeros
//  enable     in   1           0 = all anodes off; counters keep running
//  seg        out  8           active-low {dp,g,f,e,d,c,b,a}, registered
//  an         out  N_DIGITS    active-low one-hot anode select, registered
//  frame_done out  1           1-cycle pulse when the digit index wraps to 0
// BEHAVIOUR
//  Reset: seg=8'hFF, an=all 1, frame_done=0.
//   Also cleared: div counter, idx, frame counter, blink phase, shadow reg, display reg.
//  Divider cnt: 0..SCAN_DIV-1, increments every cycle.
//   At cnt==SCAN_DIV-1: cnt->0 and idx advances.
//   idx: N_DIGITS-1 -> 0 wrap.
//  Frame boundary (idx wraps to 0):
//   - frame_done=1 for exactly that one cycle.
//   - display reg <= shadow.
//   - frame counter increments; at BLINK_FRAMES-1 it clears and blink phase toggles.
//  load=1: shadow <= value.
//   If load coincides with a frame boundary, display reg takes value directly (newest wins).
//   Display content therefore never changes mid-frame.
//  Outputs are registered from current-cycle state (idx, cnt, display reg, live inputs):
//   1-cycle latency.
//  Digit i visible when enable=1 and cnt>=GUARD:
//   - not blanked by blink (blink_en[i]=1 and phase=1), and
//   - not blanked as a leading zero.
//   Visible: an bit i = 0, others = 1.
//   Otherwise: an = all 1 and seg = 8'hFF.
//  Leading zero: blank_lz=1, nibble i==0, and all nibbles above i are 0. Digit 0 is never lz-blanked.
//  Decode (seg[6:0]): 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90
//   A=88 b=83 C=C6 d=A1 E=86 F=8E (hex, with dp bit set).
//  seg[7] = ~dp[i] for the visible digit.
//  Mid-operation rst: outputs return to the reset values asynchronously.
//   Scan restarts at digit 0 with cnt=0 after release.
// TESTING (N_DIGITS=4, SCAN_DIV=4, GUARD=1, BLINK_FRAMES=2)
//  Reset release, load value=16'h1234:
//   -> an sequence E,D,B,7 per slot (F in guard cycle).
//   -> seg 99,B0,A4,F9 from the second frame.
//   -> frame_done pulse every 16 cycles.
//  blank_lz=1, value=16'h0050:
//   -> digits 3,2 an=F/seg=FF; digit1 seg=92; digit0 seg=C0.
//  value=0, blank_lz=1 -> only digit 0 lit, seg=C0.
//  load 16'hAAAA mid-frame then 16'hBBBB on the frame_done cycle:
//   -> next frame shows all 83.
//   -> no A digit appears in the current frame.
//  blink_en=4'b0001: digit 0 lit 2 frames, dark 2 frames, repeating.
//   dp=4'b0100 -> digit 2 seg[7]=0.
//  enable=0 -> an=F, seg=FF, frame_done still pulses.
//   Assert rst mid-slot -> immediate reset values; after release first lit an=E.

Source files
------------

// File: rtl/scan_display_ctrl.sv
// rtl/scan_display_ctrl.sv - multiplexed N-digit 7-segment scanner with frame-synchronous update
module scan_display_ctrl #(
    parameter int N_DIGITS     = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int GUARD        = 16,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic                  load,
    input  logic [N_DIGITS-1:0]   dp,
    input  logic [N_DIGITS-1:0]   blink_en,
    input  logic                  blank_lz,
    input  logic                  enable,
    output logic [7:0]            seg,
    output logic [N_DIGITS-1:0]   an,
    output logic                  frame_done
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [FW-1:0]         frame_cnt;
    logic                  blink_phase;
    logic [4*N_DIGITS-1:0] shadow;
    logic [4*N_DIGITS-1:0] disp;

    logic                  slot_end;
    logic                  wrap;
    logic                  guard_ok;

    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_blink;
    logic                  cur_lz;
    logic [N_DIGITS-1:0]   cur_sel;
    logic [N_DIGITS-1:0]   lz;
    logic                  zero_above;
    logic                  visible;
    logic [7:0]            seg_next;
    logic [N_DIGITS-1:0]   an_next;

    function automatic logic [6:0] dec7(input logic [3:0] n);
        logic [7:0] d;
        case (n)
            4'h0: d = 8'hC0;
            4'h1: d = 8'hF9;
            4'h2: d = 8'hA4;
            4'h3: d = 8'hB0;
            4'h4: d = 8'h99;
            4'h5: d = 8'h92;
            4'h6: d = 8'h82;
            4'h7: d = 8'hF8;
            4'h8: d = 8'h80;
            4'h9: d = 8'h90;
            4'hA: d = 8'h88;
            4'hB: d = 8'h83;
            4'hC: d = 8'hC6;
            4'hD: d = 8'hA1;
            4'hE: d = 8'h86;
            4'hF: d = 8'h8E;
        endcase
        return d[6:0];
    endfunction

    assign slot_end   = (cnt == CW'(SCAN_DIV - 1));
    assign wrap       = slot_end && (idx == IW'(N_DIGITS - 1));
    assign frame_done = wrap;

    generate
        if (GUARD == 0) begin : g_no_guard
            assign guard_ok = 1'b1;
        end else begin : g_guard
            assign guard_ok = (cnt >= CW'(GUARD));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= wrap ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (wrap) begin
            if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    // The display register only moves at a frame boundary; a load landing on
    // that same cycle bypasses the shadow so the newest value is shown.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= '0;
            disp   <= '0;
        end else begin
            if (load) begin
                shadow <= value;
            end
            if (wrap) begin
                disp <= load ? value : shadow;
            end
        end
    end

    always_comb begin
        lz         = '0;
        zero_above = 1'b1;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            lz[i]      = blank_lz && zero_above && (disp[4*i +: 4] == 4'h0) && (i != 0);
            zero_above = zero_above && (disp[4*i +: 4] == 4'h0);
        end
    end

    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blink = 1'b0;
        cur_lz    = 1'b0;
        cur_sel   = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_nib    = disp[4*i +: 4];
                cur_dp     = dp[i];
                cur_blink  = blink_en[i];
                cur_lz     = lz[i];
                cur_sel[i] = 1'b1;
            end
        end
    end

    always_comb begin
        visible  = enable && guard_ok && !(cur_blink && blink_phase) && !cur_lz;
        seg_next = 8'hFF;
        an_next  = '1;
        if (visible) begin
            seg_next = {~cur_dp, dec7(cur_nib)};
            an_next  = ~cur_sel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg <= 8'hFF;
            an  <= '1;
        end else begin
            seg <= seg_next;
            an  <= an_next;
        end
    end

endmodule

// File: tb/tb_scan_display_ctrl.sv
// tb/tb_scan_display_ctrl.sv - directed bench for scan_display_ctrl
module tb_scan_display_ctrl;

    logic        clk;
    logic        rst;
    logic [15:0] value;
    logic        load;
    logic [3:0]  dp;
    logic [3:0]  blink_en;
    logic        blank_lz;
    logic        enable;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        frame_done;

    int total = 0;
    int bad   = 0;

    scan_display_ctrl #(
        .N_DIGITS    (4),
        .SCAN_DIV    (4),
        .GUARD       (1),
        .BLINK_FRAMES(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .value     (value),
        .load      (load),
        .dp        (dp),
        .blink_en  (blink_en),
        .blank_lz  (blank_lz),
        .enable    (enable),
        .seg       (seg),
        .an        (an),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One 16-cycle frame starting aligned at cnt=0, idx=0.
    // ean nibble s / eseg byte s give the lit anode/segments for slot s.
    task automatic run_frame(input string tag, input logic [15:0] ean, input logic [31:0] eseg,
                             input int l1, input logic [15:0] v1,
                             input int l2, input logic [15:0] v2);
        int k;
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 4; c++) begin
                k    = s * 4 + c;
                load = (k == l1) || (k == l2);
                if (k == l1) value = v1;
                if (k == l2) value = v2;
                tick();
                load = 1'b0;
                if (c == 0) begin
                    chk($sformatf("%s an s%0d c%0d", tag, s, c), {28'd0, an}, 32'hF);
                    chk($sformatf("%s seg s%0d c%0d", tag, s, c), {24'd0, seg}, 32'hFF);
                end else begin
                    chk($sformatf("%s an s%0d c%0d", tag, s, c), {28'd0, an}, {28'd0, ean[4*s +: 4]});
                    chk($sformatf("%s seg s%0d c%0d", tag, s, c), {24'd0, seg}, {24'd0, eseg[8*s +: 8]});
                end
                chk($sformatf("%s fd s%0d c%0d", tag, s, c), {31'd0, frame_done},
                    {31'd0, (s == 3 && c == 2) ? 1'b1 : 1'b0});
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        value    = 16'h0000;
        load     = 1'b0;
        dp       = 4'b0000;
        blink_en = 4'b0000;
        blank_lz = 1'b0;
        enable   = 1'b1;

        tick();
        tick();
        chk("reset seg", {24'd0, seg}, 32'hFF);
        chk("reset an", {28'd0, an}, 32'hF);
        chk("reset fd", {31'd0, frame_done}, 32'h0);
        rst = 1'b0;

        // Load 1234: first frame still shows the cleared display, second shows 1234.
        run_frame("A", 16'h7BDE, 32'hC0C0C0C0, 0, 16'h1234, -1, 16'h0);
        run_frame("B", 16'h7BDE, 32'hF9A4B099, -1, 16'h0, -1, 16'h0);

        blank_lz = 1'b1;
        run_frame("C", 16'h7BDE, 32'hF9A4B099, 0, 16'h0050, -1, 16'h0);
        run_frame("D", 16'hFFDE, 32'hFFFF92C0, 0, 16'h0000, -1, 16'h0);

        // AAAA mid-frame then BBBB on the frame_done cycle; AAAA never shows.
        run_frame("E", 16'hFFFE, 32'hFFFFFFC0, 5, 16'hAAAA, 15, 16'hBBBB);
        blank_lz = 1'b0;
        run_frame("F", 16'h7BDE, 32'h83838383, -1, 16'h0, -1, 16'h0);

        // Frames G,H fall in blink phase 1; I,J in phase 0.
        blink_en = 4'b0001;
        dp       = 4'b0100;
        run_frame("G", 16'h7BDF, 32'h830383FF, -1, 16'h0, -1, 16'h0);
        run_frame("H", 16'h7BDF, 32'h830383FF, -1, 16'h0, -1, 16'h0);
        run_frame("I", 16'h7BDE, 32'h83038383, -1, 16'h0, -1, 16'h0);
        run_frame("J", 16'h7BDE, 32'h83038383, -1, 16'h0, -1, 16'h0);

        enable = 1'b0;
        run_frame("K", 16'hFFFF, 32'hFFFFFFFF, -1, 16'h0, -1, 16'h0);

        enable   = 1'b1;
        blink_en = 4'b0000;
        dp       = 4'b0000;
        for (int i = 0; i < 6; i++) tick();
        chk("pre-rst an", {28'd0, an}, 32'hD);
        chk("pre-rst seg", {24'd0, seg}, 32'h83);
        rst = 1'b1;
        #1;
        chk("async rst seg", {24'd0, seg}, 32'hFF);
        chk("async rst an", {28'd0, an}, 32'hF);
        chk("async rst fd", {31'd0, frame_done}, 32'h0);
        tick();
        rst = 1'b0;
        run_frame("M", 16'h7BDE, 32'hC0C0C0C0, -1, 16'h0, -1, 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
